// File: rtl/mb_valid_train_ctrl_pkg.sv
// Shared constants for the mainband valid-lane training sequencer.
// FSM codes, test-mode encodings and detector mode codes.
package mb_pkg;

  localparam int THR_W = 12;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CLEAR  = 3'd1;
  localparam logic [2:0] ST_RUN    = 3'd2;
  localparam logic [2:0] ST_SETTLE = 3'd3;
  localparam logic [2:0] ST_REPORT = 3'd4;

  localparam logic VAL_MODE_ITER128 = 1'b0;
  localparam logic VAL_MODE_CONS16  = 1'b1;

  // Detector mode code is {enable_cons, enable_128}
  localparam logic [1:0] DET_MODE_IDLE    = 2'b00;
  localparam logic [1:0] DET_MODE_ITER128 = 2'b01;
  localparam logic [1:0] DET_MODE_CONS16  = 2'b10;

  function automatic logic [1:0] det_mode(
    input logic mode
  );
    return (mode == VAL_MODE_CONS16) ?
      DET_MODE_CONS16 : DET_MODE_ITER128;
  endfunction

endpackage

// File: rtl/mb_valid_train_ctrl_if.sv
// Control/status bundle between the MB training LTSM,
// the valid-lane detector and the VALTRAIN sequencer.
interface mb_valid_train_ctrl_if;
  import mb_pkg::*;

  logic             i_start;
  logic             i_mode;
  logic [THR_W-1:0] i_error_threshold;
  logic             i_abort;
  logic             i_frame_valid;
  logic             i_detection_result;
  logic             o_enable_detector;
  logic             o_enable_cons;
  logic             o_enable_128;
  logic [THR_W-1:0] o_error_threshold;
  logic             o_busy;
  logic             o_done;
  logic             o_pass;

  modport master (
    output i_start,
    output i_mode,
    output i_error_threshold,
    output i_abort,
    output i_frame_valid,
    output i_detection_result,
    input  o_enable_detector,
    input  o_enable_cons,
    input  o_enable_128,
    input  o_error_threshold,
    input  o_busy,
    input  o_done,
    input  o_pass
  );

  modport slave (
    input  i_start,
    input  i_mode,
    input  i_error_threshold,
    input  i_abort,
    input  i_frame_valid,
    input  i_detection_result,
    output o_enable_detector,
    output o_enable_cons,
    output o_enable_128,
    output o_error_threshold,
    output o_busy,
    output o_done,
    output o_pass
  );

endinterface

// File: rtl/mb_valid_train_ctrl.sv
// VALTRAIN sequencer: clears the valid-lane detector, gates it per frame,
// bounds the test by frame count and latches a pass/fail result.
module mb_valid_train_ctrl
  import mb_pkg::*;
#(
  parameter int ITER_COUNT = 128,
  parameter int MAX_FRAMES = 1024,
  parameter int CNT_W      = 11
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  mb_valid_train_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_SAT  = '1;
  localparam logic [CNT_W-1:0] ITER_END = CNT_W'(ITER_COUNT);
  localparam logic [CNT_W-1:0] CONS_END = CNT_W'(MAX_FRAMES - 1);

  logic [2:0]       state_q;
  logic [2:0]       state_d;
  logic             mode_q;
  logic [THR_W-1:0] thr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             run_seen_q;
  logic             pass_q;

  logic             idle;
  logic             abort;
  logic             accept;
  logic             iter_last;
  logic             cons_last;
  logic             cons_hit;
  logic             det_en;
  logic [1:0]       det_code;

  assign idle   = (state_q == ST_IDLE);
  assign abort  = bus.i_abort && !idle;
  assign accept = (state_q == ST_RUN) && bus.i_frame_valid;

  // Frame ITER_COUNT+1 closes the window; it is enabled but unjudged
  assign iter_last = accept && (mode_q == VAL_MODE_ITER128)
                   && (cnt_q == ITER_END);
  assign cons_last = accept && (mode_q == VAL_MODE_CONS16)
                   && (cnt_q == CONS_END);

  // First RUN cycle still shows the result left over from CLEAR
  assign cons_hit = (state_q == ST_RUN)
                  && (mode_q == VAL_MODE_CONS16)
                  && run_seen_q && bus.i_detection_result;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (bus.i_start) state_d = ST_CLEAR;
      ST_CLEAR:  state_d = ST_RUN;
      ST_RUN: begin
        if (cons_hit)
          state_d = ST_REPORT;
        else if (iter_last || cons_last)
          state_d = ST_SETTLE;
      end
      ST_SETTLE: state_d = ST_REPORT;
      ST_REPORT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      mode_q     <= VAL_MODE_ITER128;
      thr_q      <= '0;
      cnt_q      <= '0;
      run_seen_q <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_seen_q <= (state_q == ST_RUN);
      if (idle && bus.i_start) begin
        mode_q <= bus.i_mode;
        thr_q  <= bus.i_error_threshold;
      end
      if (state_q == ST_CLEAR)
        cnt_q <= '0;
      else if (accept && cnt_q != CNT_SAT)
        cnt_q <= cnt_q + 1'b1;
      if (idle && bus.i_start)
        pass_q <= 1'b0;
      else if (abort)
        pass_q <= 1'b0;
      else if (cons_hit)
        pass_q <= 1'b1;
      else if (state_q == ST_SETTLE)
        pass_q <= bus.i_detection_result;
    end
  end

  always_comb begin
    det_en   = 1'b0;
    det_code = DET_MODE_IDLE;
    unique case (1'b1)
      (state_q == ST_CLEAR): det_en = 1'b1;
      (state_q == ST_RUN): begin
        det_en   = bus.i_frame_valid;
        det_code = det_mode(mode_q);
      end
      (state_q == ST_SETTLE): det_code = det_mode(mode_q);
      default: ;
    endcase
    if (abort) det_en = 1'b0;
  end

  assign bus.o_enable_detector = det_en;
  assign bus.o_enable_cons     = det_code[1];
  assign bus.o_enable_128      = det_code[0];
  assign bus.o_error_threshold = thr_q;
  assign bus.o_busy            = !idle;
  assign bus.o_done            = (state_q == ST_REPORT);
  assign bus.o_pass            = pass_q;

endmodule

// File: tb/tb_mb_valid_train_ctrl.sv
// Bench for the VALTRAIN sequencer with a behavioural valid-lane detector.
// Expected results are queued at start; a monitor checks each done pulse.
module tb_mb_valid_train_ctrl;
  import mb_pkg::*;

  localparam int          MAXF = 16;
  localparam logic [31:0] PAT  = 32'hF0F0F0F0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mb_valid_train_ctrl_if bus();

  mb_valid_train_ctrl #(
    .ITER_COUNT(128),
    .MAX_FRAMES(MAXF),
    .CNT_W(11)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .bus(bus)
  );

  // Behavioural detector
  logic [31:0] data;
  logic        det_res;
  logic [15:0] err_sum;
  logic [4:0]  run_len;

  function automatic logic [4:0] cons_next(
    input logic [4:0]  rl,
    input logic [31:0] d
  );
    logic [4:0] r;
    r = rl;
    for (int b = 0; b < 4; b++) begin
      if (d[8*b +: 8] == 8'hF0)
        r = (r >= 5'd16) ? 5'd16 : r + 5'd1;
      else
        r = 5'd0;
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      det_res <= 1'b0;
      err_sum <= '0;
      run_len <= '0;
    end else if (bus.o_enable_detector) begin
      case ({bus.o_enable_cons, bus.o_enable_128})
        2'b00: begin
          det_res <= 1'b0;
          err_sum <= '0;
          run_len <= '0;
        end
        2'b01: begin
          det_res <= (err_sum <= {4'd0, bus.o_error_threshold});
          err_sum <= err_sum + 16'($countones(data ^ PAT));
        end
        2'b10: begin
          run_len <= cons_next(run_len, data);
          if (cons_next(run_len, data) == 5'd16) det_res <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.i_detection_result = det_res;

  // Scoreboard
  logic exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   done_cyc = -1;
  int   done_cnt = 0;
  int   last_frame = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.o_done) begin
      done_cnt++;
      done_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: pass=%0b none expected",
                 bus.o_pass);
      end else begin
        chk("done_pass", 32'(bus.o_pass), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic m, input logic [11:0] thr);
    bus.i_start = 1'b1;
    bus.i_mode = m;
    bus.i_error_threshold = thr;
    tick();
    bus.i_start = 1'b0;
    chk("clear_enable", 32'(bus.o_enable_detector), 32'd1);
    chk("clear_busy", 32'(bus.o_busy), 32'd1);
    tick();
  endtask

  task automatic frame(input logic [31:0] d, input int gap);
    repeat (gap) tick();
    data = d;
    bus.i_frame_valid = 1'b1;
    last_frame = cyc;
    tick();
    bus.i_frame_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int lmin,
                           input int lmax);
    int n;
    int lat;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: no done after %0d cycles", name, n);
      exp_q.delete();
    end else begin
      lat = done_cyc - last_frame;
      if (lat < lmin || lat > lmax) begin
        errors++;
        $display("FAIL %s_latency: got %0d expected %0d..%0d",
                 name, lat, lmin, lmax);
      end
    end
    tick();
  endtask

  int dc;

  initial begin
    bus.i_start = 1'b0;
    bus.i_mode = 1'b0;
    bus.i_error_threshold = '0;
    bus.i_abort = 1'b0;
    bus.i_frame_valid = 1'b0;
    data = '0;
    #1;
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    chk("rst_done", 32'(bus.o_done), 32'd0);
    chk("rst_pass", 32'(bus.o_pass), 32'd0);
    chk("rst_en", 32'(bus.o_enable_detector), 32'd0);
    chk("rst_thr", 32'(bus.o_error_threshold), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // ITER, clean frames with gaps
    exp_q.push_back(1'b1);
    start(VAL_MODE_ITER128, 12'd0);
    for (int i = 0; i < 129; i++) frame(PAT, i % 3);
    wait_done("iter_clean", 2, 3);

    // ITER, 8 flipped bits in frame 6
    exp_q.push_back(1'b0);
    start(VAL_MODE_ITER128, 12'd3);
    for (int i = 0; i < 129; i++)
      frame((i == 5) ? (PAT ^ 32'h0000_00FF) : PAT, 0);
    wait_done("iter_err", 2, 3);

    // ITER, one flip in the unjudged extra frame
    exp_q.push_back(1'b1);
    start(VAL_MODE_ITER128, 12'd0);
    for (int i = 0; i < 129; i++)
      frame((i == 128) ? (PAT ^ 32'h1) : PAT, 0);
    wait_done("iter_extra", 2, 3);

    // CONS, 4 clean frames
    exp_q.push_back(1'b1);
    start(VAL_MODE_CONS16, 12'd0);
    for (int i = 0; i < 4; i++) frame(PAT, 0);
    wait_done("cons_clean", 1, 3);

    // CONS, mismatch in frame 3 then 4 clean
    exp_q.push_back(1'b1);
    start(VAL_MODE_CONS16, 12'd0);
    frame(PAT, 0);
    frame(PAT, 1);
    frame(32'h0, 0);
    for (int i = 0; i < 4; i++) frame(PAT, i % 2);
    wait_done("cons_retry", 1, 3);

    // CONS, never matches: frame budget runs out
    exp_q.push_back(1'b0);
    start(VAL_MODE_CONS16, 12'd0);
    for (int i = 0; i < MAXF; i++) frame(32'h0, 0);
    wait_done("cons_timeout", 2, 2);

    // Abort mid-RUN
    dc = done_cnt;
    start(VAL_MODE_CONS16, 12'd0);
    frame(PAT, 0);
    frame(PAT, 0);
    data = PAT;
    bus.i_frame_valid = 1'b1;
    bus.i_abort = 1'b1;
    #1;
    chk("abort_en", 32'(bus.o_enable_detector), 32'd0);
    tick();
    bus.i_abort = 1'b0;
    bus.i_frame_valid = 1'b0;
    chk("abort_busy", 32'(bus.o_busy), 32'd0);
    chk("abort_pass", 32'(bus.o_pass), 32'd0);

    // Abort on the same cycle as a CONS hit
    start(VAL_MODE_CONS16, 12'd0);
    for (int i = 0; i < 4; i++) frame(PAT, 0);
    bus.i_abort = 1'b1;
    tick();
    bus.i_abort = 1'b0;
    chk("abort_hit_busy", 32'(bus.o_busy), 32'd0);
    chk("abort_hit_pass", 32'(bus.o_pass), 32'd0);
    repeat (5) tick();
    chk("abort_no_done", 32'(done_cnt), 32'(dc));

    // Fresh start after abort: stale detector result must be cleared
    exp_q.push_back(1'b1);
    start(VAL_MODE_CONS16, 12'd0);
    for (int i = 0; i < 3; i++) frame(PAT, 0);
    repeat (3) tick();
    chk("restart_wait", 32'(bus.o_busy), 32'd1);
    chk("restart_no_done", 32'(done_cnt), 32'(dc));
    frame(PAT, 0);
    wait_done("restart", 1, 3);
    repeat (3) tick();
    chk("pass_held", 32'(bus.o_pass), 32'd1);

    // Start ignored while busy, then async reset mid-RUN
    dc = done_cnt;
    start(VAL_MODE_ITER128, 12'd5);
    chk("thr_latched", 32'(bus.o_error_threshold), 32'd5);
    chk("pass_cleared", 32'(bus.o_pass), 32'd0);
    frame(PAT, 0);
    bus.i_start = 1'b1;
    bus.i_mode = VAL_MODE_CONS16;
    tick();
    bus.i_start = 1'b0;
    data = PAT;
    bus.i_frame_valid = 1'b1;
    #1;
    chk("busy_mode128", 32'(bus.o_enable_128), 32'd1);
    chk("busy_modecons", 32'(bus.o_enable_cons), 32'd0);
    chk("busy_en", 32'(bus.o_enable_detector), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.o_busy), 32'd0);
    chk("arst_en", 32'(bus.o_enable_detector), 32'd0);
    chk("arst_128", 32'(bus.o_enable_128), 32'd0);
    chk("arst_thr", 32'(bus.o_error_threshold), 32'd0);
    chk("arst_pass", 32'(bus.o_pass), 32'd0);
    bus.i_frame_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("arst_no_done", 32'(done_cnt), 32'(dc));
    chk("done_total", 32'(done_cnt), 32'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
